// File: rtl/dsm_integrator_chain_if.sv
// rtl/dsm_integrator_chain_if.sv - control, data and status bundle of the integrator chain
interface dsm_integrator_chain_if #(
    parameter int WIDTH = 36,
    parameter int ORDER = 6
);
    logic                     fs_enb;
    logic                     clr;
    logic [WIDTH-1:0]         xin;
    logic [ORDER*WIDTH-1:0]   fb;
    logic                     ovf_clr;
    logic [ORDER*WIDTH-1:0]   state;
    logic [ORDER-1:0]         ovf;
    logic                     out_valid;

    modport master (
        output fs_enb, clr, xin, fb, ovf_clr,
        input  state, ovf, out_valid
    );

    modport slave (
        input  fs_enb, clr, xin, fb, ovf_clr,
        output state, ovf, out_valid
    );
endinterface

// File: rtl/dsm_integrator_chain.sv
// rtl/dsm_integrator_chain.sv - cascade of delaying integrators with saturate/wrap and sticky overflow
module dsm_integrator_chain #(
    parameter int WIDTH    = 36,
    parameter int ORDER    = 6,
    parameter int SATURATE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dsm_integrator_chain_if.slave bus
);
    // Two guard bits hold the sum of three WIDTH-bit signed terms exactly.
    localparam int SW = WIDTH + 2;

    localparam logic signed [SW-1:0]    SMAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]    SMIN = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic        [WIDTH-1:0] WMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic        [WIDTH-1:0] WMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [ORDER*WIDTH-1:0] st_q;
    logic [ORDER*WIDTH-1:0] prev;
    logic [ORDER*WIDTH-1:0] nxt;
    logic [ORDER-1:0]       ovf_q;
    logic [ORDER-1:0]       ovf_now;
    logic                   valid_q;
    logic                   update;

    assign update = bus.fs_enb & ~bus.clr;

    // Feed-in for each stage: xin for stage 0, old registered sum of the stage below otherwise.
    always_comb begin
        prev = '0;
        prev[WIDTH-1:0] = bus.xin;
        for (int k = 1; k < ORDER; k++) begin
            prev[k*WIDTH +: WIDTH] = st_q[(k-1)*WIDTH +: WIDTH];
        end
    end

    // Full-precision stage sums, overflow detection and saturate/wrap reduction.
    always_comb begin
        logic signed [SW-1:0] t_acc;
        logic signed [SW-1:0] t_in;
        logic signed [SW-1:0] t_fb;
        logic signed [SW-1:0] t_sum;
        nxt     = '0;
        ovf_now = '0;
        t_acc   = '0;
        t_in    = '0;
        t_fb    = '0;
        t_sum   = '0;
        for (int k = 0; k < ORDER; k++) begin
            t_acc = SW'($signed(st_q[k*WIDTH +: WIDTH]));
            t_in  = SW'($signed(prev[k*WIDTH +: WIDTH]));
            t_fb  = SW'($signed(bus.fb[k*WIDTH +: WIDTH]));
            t_sum = t_acc + t_in + t_fb;
            ovf_now[k] = (t_sum > SMAX) || (t_sum < SMIN);
            if ((SATURATE != 0) && (t_sum > SMAX)) begin
                nxt[k*WIDTH +: WIDTH] = WMAX;
            end else if ((SATURATE != 0) && (t_sum < SMIN)) begin
                nxt[k*WIDTH +: WIDTH] = WMIN;
            end else begin
                nxt[k*WIDTH +: WIDTH] = t_sum[WIDTH-1:0];
            end
        end
    end

    // Stage registers, sticky overflow (set wins over ovf_clr) and update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= update;
            if (bus.clr) begin
                st_q <= '0;
            end else if (bus.fs_enb) begin
                st_q <= nxt;
            end
            ovf_q <= (bus.ovf_clr ? '0 : ovf_q) | (update ? ovf_now : '0);
        end
    end

    assign bus.state     = st_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_dsm_integrator_chain.sv
// tb/tb_dsm_integrator_chain.sv - checks saturating and wrapping chains against an arithmetic model
module tb_dsm_integrator_chain;
    localparam int W = 8;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsm_integrator_chain_if #(.WIDTH(W), .ORDER(N)) ifs ();
    dsm_integrator_chain_if #(.WIDTH(W), .ORDER(N)) ifw ();

    dsm_integrator_chain #(.WIDTH(W), .ORDER(N), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifs)
    );
    dsm_integrator_chain #(.WIDTH(W), .ORDER(N), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(ifw)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model: index 0 = saturating, 1 = wrapping
    int ms   [2][N];
    int movf [2][N];
    int mvalid;

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < N; k++) begin
                ms[m][k]   = 0;
                movf[m][k] = 0;
            end
        mvalid = 0;
    endtask

    task automatic model_step(input int fs, input int cl, input int oc, input int x,
                              input int f0, input int f1, input int f2);
        int f [N];
        int old [N];
        int sum, o;
        f[0] = f0; f[1] = f1; f[2] = f2;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N; k++) old[k] = ms[m][k];
            for (int k = 0; k < N; k++) begin
                if (oc != 0) movf[m][k] = 0;
                if (cl != 0) begin
                    ms[m][k] = 0;
                end else if (fs != 0) begin
                    sum = old[k] + ((k == 0) ? x : old[k-1]) + f[k];
                    o = (sum > 127 || sum < -128) ? 1 : 0;
                    if (o != 0) movf[m][k] = 1;
                    if (m == 0) ms[m][k] = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
                    else        ms[m][k] = ((sum + 128 + 512) % 256) - 128;
                end
            end
        end
        mvalid = (fs != 0 && cl == 0) ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        logic [N*W-1:0] st;
        logic [N-1:0]   ov;
        logic           va;
        logic signed [W-1:0] v;
        for (int m = 0; m < 2; m++) begin
            st = (m == 0) ? ifs.state : ifw.state;
            ov = (m == 0) ? ifs.ovf : ifw.ovf;
            va = (m == 0) ? ifs.out_valid : ifw.out_valid;
            for (int k = 0; k < N; k++) begin
                v = st[k*W +: W];
                n_cmp++;
                assert (int'(v) === ms[m][k]) else begin
                    n_err++;
                    $error("FAIL %s mode%0d s%0d observed=%0d expected=%0d", tag, m, k, v, ms[m][k]);
                end
                n_cmp++;
                assert (int'(ov[k]) === movf[m][k]) else begin
                    n_err++;
                    $error("FAIL %s mode%0d ovf%0d observed=%0d expected=%0d", tag, m, k, ov[k], movf[m][k]);
                end
            end
            n_cmp++;
            assert (int'(va) === mvalid) else begin
                n_err++;
                $error("FAIL %s mode%0d out_valid observed=%0d expected=%0d", tag, m, va, mvalid);
            end
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int fs, input int cl, input int oc, input int x,
                         input int f0, input int f1, input int f2);
        ifs.fs_enb = fs[0]; ifw.fs_enb = fs[0];
        ifs.clr = cl[0];    ifw.clr = cl[0];
        ifs.ovf_clr = oc[0]; ifw.ovf_clr = oc[0];
        ifs.xin = W'(x);    ifw.xin = W'(x);
        ifs.fb = {W'(f2), W'(f1), W'(f0)};
        ifw.fb = {W'(f2), W'(f1), W'(f0)};
    endtask

    task automatic step(input string tag, input int fs, input int cl, input int oc,
                        input int x, input int f0, input int f1, input int f2);
        @(negedge clk);
        drive(fs, cl, oc, x, f0, f1, f2);
        model_step(fs, cl, oc, x, f0, f1, f2);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int sv(input logic [N*W-1:0] st, input int k);
        logic [N*W-1:0] t;
        logic signed [W-1:0] v;
        t = st;
        v = t[k*W +: W];
        return int'(v);
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // impulse response with idle cycles between samples
        step("imp", 1, 0, 0, 1, 0, 0, 0);
        step("imp_idle", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step("imp", 1, 0, 0, 0, 0, 0, 0);
            step("imp_idle", 0, 0, 0, 0, 0, 0, 0);
        end
        check_val("imp_s0", sv(ifs.state, 0), 1);
        check_val("imp_s1", sv(ifs.state, 1), 4);
        check_val("imp_s2", sv(ifs.state, 2), 6);

        // hold with random junk on xin/fb
        for (int i = 0; i < 20; i++)
            step("hold", 0, 0, 0, $urandom_range(255) - 128, $urandom_range(255) - 128,
                 $urandom_range(255) - 128, 0);
        check_val("hold_s2", sv(ifs.state, 2), 6);

        // positive overflow
        do_reset("rst_a");
        step("ovp", 1, 0, 0, 100, 0, 0, 0);
        check_val("ovp_sat_1", sv(ifs.state, 0), 100);
        step("ovp", 1, 0, 0, 100, 0, 0, 0);
        check_val("ovp_sat_2", sv(ifs.state, 0), 127);
        check_val("ovp_wrap_2", sv(ifw.state, 0), -56);
        check_val("ovp_ovf_sat", int'(ifs.ovf[0]), 1);
        check_val("ovp_ovf_wrap", int'(ifw.ovf[0]), 1);
        step("ovp", 1, 0, 0, 100, 0, 0, 0);
        check_val("ovp_sat_3", sv(ifs.state, 0), 127);

        // negative overflow
        do_reset("rst_b");
        step("ovn", 1, 0, 0, -100, 0, 0, 0);
        step("ovn", 1, 0, 0, -100, 0, 0, 0);
        check_val("ovn_sat_2", sv(ifs.state, 0), -128);

        // feedback term into stage 1 only
        do_reset("rst_c");
        for (int i = 0; i < 3; i++) step("fb", 1, 0, 0, 0, 0, 5, 0);
        check_val("fb_s0", sv(ifs.state, 0), 0);
        check_val("fb_s1", sv(ifs.state, 1), 15);
        check_val("fb_s2", sv(ifs.state, 2), 15);

        // clr beats fs_enb
        do_reset("rst_d");
        step("pri_load", 1, 0, 0, 40, 0, 0, 0);
        step("pri_clr", 1, 1, 0, 40, 0, 0, 0);
        check_val("pri_clr_s0", sv(ifs.state, 0), 0);
        check_val("pri_clr_valid", int'(ifs.out_valid), 0);

        // set wins over ovf_clr, then ovf_clr alone clears
        step("ov_set", 1, 0, 0, 100, 0, 0, 0);
        step("ov_set", 1, 0, 0, 100, 0, 0, 0);
        step("ov_both", 1, 0, 1, 100, 0, 0, 0);
        check_val("ov_both_sat", int'(ifs.ovf[0]), 1);
        step("ov_clr", 0, 0, 1, 0, 0, 0, 0);
        check_val("ov_clr_sat", int'(ifs.ovf[0]), 0);

        // randomized traffic, including back-to-back samples
        do_reset("rst_e");
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(99) < 70) ? 1 : 0, ($urandom_range(99) < 4) ? 1 : 0,
                 ($urandom_range(99) < 5) ? 1 : 0, $urandom_range(255) - 128,
                 $urandom_range(63) - 32, $urandom_range(63) - 32, $urandom_range(63) - 32);
            if (i == 150) do_reset("rst_mid");
        end

        // after reset release nothing moves until a fresh fs_enb
        do_reset("rst_f");
        for (int i = 0; i < 3; i++) step("post_rst", 0, 0, 0, 55, 1, 1, 1);
        step("post_rst_go", 1, 0, 0, 55, 0, 0, 0);
        check_val("post_rst_s0", sv(ifs.state, 0), 55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsm_integrator_chain.md
# dsm_integrator_chain

Parametrised cascade of ORDER delaying (registered-output) integrators forming the loop-filter core of the sigma-delta modulators. Each stage accumulates the previous stage's registered sum plus a per-stage feedback/feed-in term, once per sample-rate enable. Arithmetic is signed, with selectable saturate or wrap behaviour, sticky per-stage overflow flags and a synchronous clear. The block replaces hand-chained single integrators in the modulator datapath; quantiser and feedback coefficient logic stay outside.

## Interface
- WIDTH, 36, signed word width of input, feedback terms and every stage state
- ORDER, 6, number of cascaded integrator stages (1..8)
- SATURATE, 1, 1 = clamp to signed range on overflow, 0 = two's-complement wrap
- clk  input  1  clock
- rst_n  input  1  reset rst_n, asynchronous, active-low; clock clk
- fs_enb  input  1  sample-rate enable, one-cycle pulse per modulator sample
- clr  input  1  synchronous clear of all stage states
- xin  input  WIDTH  signed input to stage 0
- fb  input  ORDER*WIDTH  signed per-stage add term; stage k uses fb[k*WIDTH +: WIDTH]
- ovf_clr  input  1  clears all sticky overflow flags
- state  output  ORDER*WIDTH  packed stage sums; stage k at state[k*WIDTH +: WIDTH]
- ovf  output  ORDER  sticky overflow flag per stage
- out_valid  output  1  one-cycle pulse: state updated in previous cycle

## Operation
- Stage update on cycle with fs_enb=1 and clr=0, all stages in parallel from pre-update values:
  - s0 <= f(s0 + xin + fb0)
  - sk <= f(sk + s(k-1) + fbk), k = 1..ORDER-1, s(k-1) is the old registered value (delaying integrator: one sample latency per stage)
- Sums computed sign-extended at WIDTH+2 bits; no intermediate truncation.
- f(): SATURATE=1 -> clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; SATURATE=0 -> keep low WIDTH bits.
- Overflow for stage k = full-precision sum outside signed WIDTH range; sets ovf[k] in both modes.
- fs_enb=0: all states hold; no ovf change from arithmetic.
- clr=1: all states <= 0 next edge; clr has priority over fs_enb; ovf unaffected by clr.
- ovf_clr=1: ovf <= 0, except bits with a new overflow in the same cycle, which end at 1 (set wins).
- out_valid <= fs_enb & ~clr, registered.

## Timing
- Reset values: state = 0 all stages, ovf = 0, out_valid = 0; asynchronous assert, synchronous-release behaviour per team reset scheme.
- Reset mid-operation clears everything immediately; first update after release needs a fresh fs_enb.
- Latency xin -> s0: 1 clk after fs_enb edge; xin -> s(k): k+1 fs_enb samples.
- out_valid asserted the cycle after the updating edge, coincident with new state on outputs; fs_enb on consecutive cycles is legal (every-cycle updates, out_valid held high).
- No combinational path from inputs to outputs; all outputs registered.
- Inputs xin, fb sampled only on fs_enb cycles; may change freely otherwise.

## Test plan
- Impulse, WIDTH=8, ORDER=3, fb=0: xin=1 for one sample then 0 -> s0 = 1,1,1,1,1; s1 = 0,1,2,3,4; s2 = 0,0,1,3,6 across five fs_enb pulses; ovf=0; out_valid pulses once per sample.
- Saturation, WIDTH=8, SATURATE=1: xin=100 constant -> s0 = 100 then 127 and stays 127; ovf[0]=1 after sample 2; negative drive xin=-100 from reset -> -100 then -128.
- Wrap, WIDTH=8, SATURATE=0: xin=100 -> s0 = 100 then -56; ovf[0]=1.
- Feedback term: xin=0, fb stage1=5, others 0 -> s1 = 5,10,15; s0 stays 0; s2 = 0,5,15.
- Priority: clr and fs_enb same cycle with s0=40 -> all states 0, out_valid=0; ovf_clr coincident with new overflow -> ovf bit remains 1; ovf_clr alone -> 0.
- Hold and reset: fs_enb low 20 cycles -> state unchanged; rst_n low mid-sequence -> state, ovf, out_valid 0 within same cycle, held until fs_enb after release.
